// File: rtl/rv64g_l2_evict.sv
// L2 eviction engine: picks a victim way in one set, writes it back if dirty,
// invalidates it if valid, and hands the freed way to the miss handler.
module rv64g_l2_evict #(
    parameter int PADDR_W = 56,
    parameter int TAG_W   = PADDR_W - 14,
    parameter int BEATS   = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [7:0]         req_set_i,
    output logic               meta_rd_o,
    output logic [7:0]         meta_set_o,
    input  logic [15:0]        meta_valid_i,
    input  logic [15:0]        meta_dirty_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic [3:0]         meta_way_o,
    output logic               meta_inv_o,
    output logic [7:0]         plru_set_o,
    output logic [15:0]        plru_valid_o,
    input  logic [3:0]         plru_victim_i,
    output logic               plru_access_o,
    output logic [3:0]         plru_way_o,
    output logic               data_rd_o,
    output logic [3:0]         data_way_o,
    output logic [2:0]         data_beat_o,
    input  logic [63:0]        data_rdata_i,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [PADDR_W-1:0] wb_addr_o,
    output logic [63:0]        wb_data_o,
    output logic               wb_last_o,
    output logic               done_valid_o,
    input  logic               done_ready_i,
    output logic [3:0]         done_way_o,
    output logic               done_wb_o
);

    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MASK, S_TAG, S_RD, S_SEND, S_INV, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         set_q, set_d;
    logic [15:0]        dirty_q, dirty_d;
    logic [3:0]         victim_q, victim_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [2:0]         beat_q, beat_d;
    logic               first_q, first_d;
    logic [63:0]        wbd_q, wbd_d;
    logic               wbflag_q, wbflag_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            set_q    <= '0;
            dirty_q  <= '0;
            victim_q <= '0;
            tag_q    <= '0;
            beat_q   <= '0;
            first_q  <= 1'b0;
            wbd_q    <= '0;
            wbflag_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            set_q    <= set_d;
            dirty_q  <= dirty_d;
            victim_q <= victim_d;
            tag_q    <= tag_d;
            beat_q   <= beat_d;
            first_q  <= first_d;
            wbd_q    <= wbd_d;
            wbflag_q <= wbflag_d;
        end
    end

    // Valid/ready: a transfer happens on every rising edge where both are high;
    // once valid is raised the payload stays stable until that edge.
    always_comb begin
        state_d       = state_q;
        set_d         = set_q;
        dirty_d       = dirty_q;
        victim_d      = victim_q;
        tag_d         = tag_q;
        beat_d        = beat_q;
        first_d       = first_q;
        wbd_d         = wbd_q;
        wbflag_d      = wbflag_q;
        req_ready_o   = 1'b0;
        meta_rd_o     = 1'b0;
        meta_set_o    = set_q;
        meta_way_o    = victim_q;
        meta_inv_o    = 1'b0;
        plru_set_o    = set_q;
        plru_valid_o  = '0;
        plru_access_o = 1'b0;
        plru_way_o    = '0;
        data_rd_o     = 1'b0;
        data_way_o    = '0;
        data_beat_o   = '0;
        wb_valid_o    = 1'b0;
        wb_addr_o     = '0;
        wb_data_o     = '0;
        wb_last_o     = 1'b0;
        done_valid_o  = 1'b0;
        done_way_o    = '0;
        done_wb_o     = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    set_d      = req_set_i;
                    meta_rd_o  = 1'b1;
                    meta_set_o = req_set_i;
                    wbflag_d   = 1'b0;
                    state_d    = S_MASK;
                end
            end
            S_MASK: begin
                plru_valid_o = meta_valid_i;
                dirty_d      = meta_dirty_i;
                victim_d     = plru_victim_i;
                if (meta_valid_i[plru_victim_i]) begin
                    meta_rd_o  = 1'b1;
                    meta_way_o = plru_victim_i;
                    state_d    = S_TAG;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_TAG: begin
                tag_d = tag_i;
                if (dirty_q[victim_q]) begin
                    beat_d  = '0;
                    state_d = S_RD;
                end else begin
                    state_d = S_INV;
                end
            end
            S_RD: begin
                data_rd_o   = 1'b1;
                data_way_o  = victim_q;
                data_beat_o = beat_q;
                first_d     = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                // Read data arrives in the first SEND cycle; pass it straight
                // through then and replay the captured copy during stalls.
                wb_valid_o = 1'b1;
                wb_addr_o  = {tag_q, set_q, 6'b0};
                wb_data_o  = first_q ? data_rdata_i : wbd_q;
                wb_last_o  = (beat_q == LAST_BEAT);
                if (first_q) begin
                    wbd_d   = data_rdata_i;
                    first_d = 1'b0;
                end
                if (wb_ready_i) begin
                    if (beat_q == LAST_BEAT) begin
                        wbflag_d = 1'b1;
                        state_d  = S_INV;
                    end else begin
                        beat_d  = beat_q + 3'd1;
                        state_d = S_RD;
                    end
                end
            end
            S_INV: begin
                meta_inv_o = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                done_valid_o = 1'b1;
                done_way_o   = victim_q;
                done_wb_o    = wbflag_q;
                if (done_ready_i) begin
                    plru_access_o = 1'b1;
                    plru_way_o    = victim_q;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rv64g_l2_evict.sv
// Directed bench for rv64g_l2_evict with metadata/data/PLRU responders and a
// writeback scoreboard.
module tb_rv64g_l2_evict;

    localparam int PADDR_W = 56;
    localparam int TAG_W   = PADDR_W - 14;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               req_valid_i;
    logic               req_ready_o;
    logic [7:0]         req_set_i;
    logic               meta_rd_o;
    logic [7:0]         meta_set_o;
    logic [15:0]        meta_valid_i = '0;
    logic [15:0]        meta_dirty_i = '0;
    logic [TAG_W-1:0]   tag_i = '0;
    logic [3:0]         meta_way_o;
    logic               meta_inv_o;
    logic [7:0]         plru_set_o;
    logic [15:0]        plru_valid_o;
    logic [3:0]         plru_victim_i;
    logic               plru_access_o;
    logic [3:0]         plru_way_o;
    logic               data_rd_o;
    logic [3:0]         data_way_o;
    logic [2:0]         data_beat_o;
    logic [63:0]        data_rdata_i = '0;
    logic               wb_valid_o;
    logic               wb_ready_i;
    logic [PADDR_W-1:0] wb_addr_o;
    logic [63:0]        wb_data_o;
    logic               wb_last_o;
    logic               done_valid_o;
    logic               done_ready_i;
    logic [3:0]         done_way_o;
    logic               done_wb_o;

    rv64g_l2_evict dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_set_i(req_set_i),
        .meta_rd_o(meta_rd_o), .meta_set_o(meta_set_o),
        .meta_valid_i(meta_valid_i), .meta_dirty_i(meta_dirty_i), .tag_i(tag_i),
        .meta_way_o(meta_way_o), .meta_inv_o(meta_inv_o),
        .plru_set_o(plru_set_o), .plru_valid_o(plru_valid_o), .plru_victim_i(plru_victim_i),
        .plru_access_o(plru_access_o), .plru_way_o(plru_way_o),
        .data_rd_o(data_rd_o), .data_way_o(data_way_o), .data_beat_o(data_beat_o),
        .data_rdata_i(data_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_addr_o(wb_addr_o),
        .wb_data_o(wb_data_o), .wb_last_o(wb_last_o),
        .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
        .done_way_o(done_way_o), .done_wb_o(done_wb_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    // Current set contents, as seen by the responders.
    logic [15:0]        mv;
    logic [15:0]        md;
    logic [TAG_W-1:0]   mtag;
    logic [3:0]         plru_pick;
    logic [PADDR_W-1:0] exp_addr;
    logic [7:0]         cur_set;

    int          inv_cnt, acc_cnt, hs_cnt;
    logic [7:0]  inv_set;
    logic [3:0]  inv_way, acc_way;
    logic        held;
    logic [63:0] prev_data;
    int          stall_beat = -1;
    int          stall_left = 0;
    int          lat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [3:0] w, input logic [2:0] b);
        return {16'hDA7A, 12'h000, w, 29'h0, b};
    endfunction

    // PLRU model: lowest invalid way first, otherwise the configured pick.
    always_comb begin
        plru_victim_i = plru_pick;
        for (int i = 15; i >= 0; i--)
            if (!plru_valid_o[i]) plru_victim_i = 4'(i);
    end

    always @(posedge clk_i) begin
        meta_valid_i <= meta_rd_o ? mv : 16'h0000;
        meta_dirty_i <= meta_rd_o ? md : ~md;
        tag_i        <= meta_rd_o ? mtag : ~mtag;
        data_rdata_i <= data_rd_o ? beat_data(data_way_o, data_beat_o) : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    always @(posedge clk_i) begin
        #1;
        if (stall_left > 0 && wb_valid_o && hs_cnt == stall_beat) begin
            wb_ready_i = 1'b0;
            stall_left--;
        end else begin
            wb_ready_i = 1'b1;
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (meta_inv_o) begin
                inv_cnt++;
                inv_set = meta_set_o;
                inv_way = meta_way_o;
            end
            if (plru_access_o) begin
                acc_cnt++;
                acc_way = plru_way_o;
                check("acc_set", plru_set_o, cur_set);
                check("acc_in_hs", done_valid_o & done_ready_i, 1);
            end
            if (wb_valid_o) begin
                check("wb_addr", wb_addr_o, exp_addr);
                if (held) check("wb_hold", wb_data_o, prev_data);
                if (wb_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("wb_extra", 1, 0);
                    end else begin
                        check("wb_data", wb_data_o, exp_q.pop_front());
                        check("wb_last", wb_last_o, hs_cnt == 7);
                    end
                    hs_cnt++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    prev_data = wb_data_o;
                end
            end
        end
    end

    task automatic setup(input logic [7:0] s, input logic [15:0] v, input logic [15:0] d,
                         input logic [3:0] pick, input logic [TAG_W-1:0] t);
        cur_set = s; mv = v; md = d; plru_pick = pick; mtag = t;
        exp_addr = {t, s, 6'b0};
        inv_cnt = 0; acc_cnt = 0; hs_cnt = 0; held = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_beats(input logic [3:0] w);
        for (int b = 0; b < 8; b++) exp_q.push_back(beat_data(w, 3'(b)));
    endtask

    task automatic start_req(input logic [7:0] s);
        int g;
        g = 0;
        @(negedge clk_i);
        while (!req_ready_o && g < 50) begin
            @(negedge clk_i);
            g++;
        end
        check("req_ready", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_set_i   = s;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_set_i   = 8'hEE;
    endtask

    task automatic run_req(input logic [7:0] s, output int l);
        start_req(s);
        l = 1;
        while (l < 200) begin
            @(negedge clk_i);
            if (done_valid_o) break;
            @(posedge clk_i);
            l++;
        end
        if (!done_valid_o) check("done_timeout", 0, 1);
    endtask

    task automatic accept_done(input int hold, input logic [3:0] way, input logic wb);
        int a0;
        a0 = acc_cnt;
        check("done_way", done_way_o, way);
        check("done_wb", done_wb_o, wb);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            check("done_hold", done_valid_o, 1);
            check("done_way_hold", done_way_o, way);
            check("busy_ready", req_ready_o, 0);
        end
        check("acc_before_hs", acc_cnt - a0, 0);
        @(posedge clk_i);
        #1;
        done_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        done_ready_i = 1'b0;
        check("acc_once", acc_cnt - a0, 1);
        check("acc_way", acc_way, way);
        check("done_drop", done_valid_o, 0);
        check("idle_ready", req_ready_o, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; req_valid_i = 1'b0; req_set_i = 8'h00;
        done_ready_i = 1'b0; wb_ready_i = 1'b1;
        setup(8'h00, 16'hFFFF, 16'h0000, 4'h0, '0);
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_req_ready", req_ready_o, 1);
        check("rst_meta_rd", meta_rd_o, 0);
        check("rst_meta_inv", meta_inv_o, 0);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_done_valid", done_valid_o, 0);
        check("rst_plru_acc", plru_access_o, 0);
        check("rst_data_rd", data_rd_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Invalid way 3 chosen ahead of the PLRU pick.
        setup(8'h12, 16'hFFF7, 16'hFFFF, 4'hC, 42'h111);
        run_req(8'h12, lat);
        check("inv_victim_lat", lat, 2);
        accept_done(0, 4'd3, 1'b0);
        check("inv_victim_no_inv", inv_cnt, 0);
        check("inv_victim_no_wb", hs_cnt, 0);

        // Clean valid victim 9.
        setup(8'h40, 16'hFFFF, 16'h0000, 4'd9, 42'h077);
        run_req(8'h40, lat);
        check("clean_lat", lat, 4);
        accept_done(0, 4'd9, 1'b0);
        check("clean_inv_cnt", inv_cnt, 1);
        check("clean_inv_set", inv_set, 8'h40);
        check("clean_inv_way", inv_way, 4'd9);
        check("clean_no_wb", hs_cnt, 0);

        // Dirty victim 5, no stalls.
        setup(8'hA5, 16'hFFFF, 16'h0020, 4'd5, 42'h123);
        push_beats(4'd5);
        run_req(8'hA5, lat);
        check("dirty_lat", lat, 20);
        check("dirty_inv_cnt", inv_cnt, 1);
        check("dirty_inv_set", inv_set, 8'hA5);
        check("dirty_inv_way", inv_way, 4'd5);
        check("dirty_beats", hs_cnt, 8);
        check("dirty_left", exp_q.size(), 0);
        accept_done(0, 4'd5, 1'b1);

        // Dirty victim 14 with a 3-cycle stall on beat 4.
        setup(8'h3C, 16'hFFFF, 16'h4000, 4'd14, 42'h2_0000_0ABC);
        push_beats(4'd14);
        stall_beat = 4; stall_left = 3;
        run_req(8'h3C, lat);
        check("stall_lat", lat, 23);
        check("stall_beats", hs_cnt, 8);
        check("stall_left", exp_q.size(), 0);
        accept_done(0, 4'd14, 1'b1);
        stall_beat = -1;

        // Reset in the middle of beat 2.
        setup(8'h21, 16'hFFFF, 16'h0004, 4'd2, 42'h055);
        push_beats(4'd2);
        start_req(8'h21);
        for (int g = 0; g < 100 && !(hs_cnt == 2 && wb_valid_o); g++) @(negedge clk_i);
        check("rst_reach_beat2", hs_cnt, 2);
        #1;
        rst_ni = 1'b0;
        #1;
        check("midrst_wb_valid", wb_valid_o, 0);
        check("midrst_done_valid", done_valid_o, 0);
        check("midrst_req_ready", req_ready_o, 1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        setup(8'h33, 16'hFFFF, 16'h0000, 4'd7, 42'h0AA);
        run_req(8'h33, lat);
        check("post_rst_lat", lat, 4);
        check("post_rst_inv_way", inv_way, 4'd7);
        check("post_rst_no_wb", hs_cnt, 0);
        accept_done(0, 4'd7, 1'b0);

        // Done held off for five cycles.
        setup(8'h99, 16'h7FFF, 16'h0000, 4'd0, 42'h0);
        run_req(8'h99, lat);
        check("hold_lat", lat, 2);
        accept_done(5, 4'd15, 1'b0);
        check("hold_no_inv", inv_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv64g_l2_evict.md
Name: rv64g_l2_evict

Overview:
- Eviction engine for the 16-way, 256-set L2. Sits between the miss handler and the replacement/metadata/data arrays.
- On a miss request it reads the set's valid/dirty masks and presents the valid mask to the PLRU victim selector. It then samples the chosen way.
- A dirty victim is written back as 8 x 64-bit beats on a valid/ready channel. A valid victim is then invalidated, and the freed way is returned to the miss handler.

Parameters:
- PADDR_W, 56, physical address width.
- TAG_W, PADDR_W-14, tag width; 8 set bits and 6 offset bits lie below the tag.
- BEATS, 8, writeback beats per 64 B line; fixed at 8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  eviction request
- req_ready_o  out  1  high only in IDLE
- req_set_i  in  8  set index to free a way in
- meta_rd_o  out  1  metadata read strobe; data returns next cycle
- meta_set_o  out  8  set for metadata read/write
- meta_valid_i  in  16  per-way valid mask, valid the cycle after meta_rd_o
- meta_dirty_i  in  16  per-way dirty mask, same timing as meta_valid_i
- tag_i  in  TAG_W  tag of the way on meta_way_o, valid the cycle after meta_rd_o
- meta_way_o  out  4  way for tag read / invalidate
- meta_inv_o  out  1  one-cycle pulse: clear valid and dirty of meta_set_o/meta_way_o
- plru_set_o  out  8  set index to PLRU
- plru_valid_o  out  16  valid mask to PLRU
- plru_victim_i  in  4  combinational victim from PLRU
- plru_access_o  out  1  one-cycle pulse: mark the way as used
- plru_way_o  out  4  way for plru_access_o
- data_rd_o  out  1  data read strobe; data returns next cycle
- data_way_o  out  4  way for the data read
- data_beat_o  out  3  beat index for the data read
- data_rdata_i  in  64  read data
- wb_valid_o  out  1  writeback beat valid
- wb_ready_i  in  1  writeback beat accepted
- wb_addr_o  out  PADDR_W  line address {tag, set, 6'b0}, constant for all beats
- wb_data_o  out  64  writeback beat data
- wb_last_o  out  1  high on beat 7
- done_valid_o  out  1  eviction complete
- done_ready_i  in  1  miss handler accepts the done result
- done_way_o  out  4  freed way
- done_wb_o  out  1  a writeback occurred

Behaviour:
- Reset: all outputs 0 except req_ready_o=1. FSM returns to IDLE and beat counter clears, regardless of current state. A partially sent writeback is abandoned.
- IDLE: req_ready_o=1. On req_valid_i, latch the set, pulse meta_rd_o with meta_set_o=set, then go to MASK.
- MASK (1 cycle):
  - Latch meta_valid_i and meta_dirty_i.
  - Drive plru_set_o=set and plru_valid_o=meta_valid_i.
  - Latch plru_victim_i as victim (combinational from the PLRU, same cycle).
  - If the victim is invalid, go to DONE with done_wb_o=0.
  - If the victim is valid, pulse meta_rd_o with meta_way_o=victim and go to TAG.
- TAG (1 cycle): latch tag_i.
  - If the victim is dirty, go to RD with beat=0.
  - If it is clean, go to INV with done_wb_o=0.
- RD: pulse data_rd_o with data_way_o=victim and data_beat_o=beat, then go to SEND.
- SEND:
  - Beat register captures data_rdata_i on the first SEND cycle. Hold wb_valid_o=1 with stable wb_data_o, wb_addr_o and wb_last_o until wb_ready_i.
  - On handshake: if beat==7, go to INV with done_wb_o=1; otherwise increment beat and go to RD.
  - Beat counter is 3 bits and must not wrap past 7.
- INV: pulse meta_inv_o with the set and victim way for exactly one cycle, then go to DONE. Never pulsed for an invalid victim.
- DONE: done_valid_o=1 with done_way_o=victim, holding until done_ready_i.
  - In the handshake cycle, pulse plru_access_o with plru_set_o=set and plru_way_o=victim, making the freed way MRU. Then go to IDLE.
  - No back-to-back acceptance: req_ready_o is low in DONE.
- One eviction in flight. req_set_i, meta and tag inputs are ignored outside their sample cycles.
- Latency with no stalls:
  - invalid victim: done_valid_o 2 cycles after the request handshake;
  - clean victim: 4 cycles;
  - dirty victim: 4 + 16 cycles. Each beat takes 2 cycles (RD, SEND) plus wb_ready_i stall cycles.

Test Plan:
- set 0x12, meta_valid=0xFFF7 -> victim must be way 3 (invalid-first in the PLRU); done_way=3, done_wb=0; no meta_inv_o, no wb_valid_o; done 2 cycles after request.
- set 0x40, all valid, dirty=0, PLRU victim=9 -> one meta_inv_o pulse (set 0x40, way 9); done_way=9, done_wb=0; plru_access_o pulse way 9 on the done handshake.
- set 0xA5, all valid, victim 5 dirty, tag=0x123 -> 8 beats with data_beat 0..7, wb_addr={0x123,0xA5,6'b0}, wb_last only on beat 7; then meta_inv_o, done_wb=1.
- Dirty writeback with wb_ready_i low for 3 cycles on beat 4 -> wb_data_o and wb_addr_o stable throughout; no beat repeated or skipped; exactly 8 handshakes.
- Assert rst_ni mid-writeback at beat 2 -> wb_valid_o=0 and done_valid_o=0 immediately; req_ready_o=1. A next request runs cleanly from MASK.
- done_ready_i low for 5 cycles -> done_valid_o and done_way_o held; req_ready_o=0; plru_access_o pulses only once, in the handshake cycle.
